mux_arb_reg: RTL and testbench
==============================

Name: mux_arb_reg

Overview:
- Parametrised N-input, WIDTH-bit stream selector; successor to the plain 2:1 combinational bus mux.
- Adds valid/ready handshakes per channel, fixed-priority or round-robin arbitration, and a registered output slot.
- Sits between multiple operand producers (e.g. partial-product or operand sources) and a single downstream consumer such as the multiplier datapath.

Parameters:
- N, 4, number of input channels; N >= 2.
- WIDTH, 8, data bus width per channel.
- CW (localparam), $clog2(N), channel-index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  arb_mode_e: 0 = FIXED (channel 0 highest priority), 1 = RR (round robin).
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; one-hot or zero.
- in_data  input  N x WIDTH  packed array [N-1:0][WIDTH-1:0] of channel data.
- out_valid  output  1  output slot holds data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  CW  index of the channel that supplied out_data.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0.
  - in_ready is therefore 0 while reset is asserted.
  - Any in-flight data is discarded.
- load_ok = !out_valid || out_ready (slot empty or draining this cycle).
- Grant (combinational): one-hot choice among asserted in_valid bits.
  - FIXED: lowest asserted index wins.
  - RR: first asserted index searching upward from ptr, wrapping N-1 -> 0.
- in_ready = grant & {N{load_ok}}.
  - in_ready may depend combinationally on in_valid.
  - in_valid must never depend on in_ready.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next clk edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 transfer/cycle while out_ready=1.
- Drain: out_valid && out_ready with no new transfer -> out_valid <= 0 next edge. Drain plus new transfer in the same cycle -> slot reloads and out_valid stays 1, with no bubble.
- Stall: out_valid && !out_ready -> out_data and out_chan held stable; all in_ready=0.
- Pointer update:
  - RR mode only: on a transfer from g, ptr <= (g == N-1) ? 0 : g+1.
  - No transfer -> ptr holds.
  - FIXED mode: ptr holds its value.
- Mode change: sampled combinationally. Affects the very next arbitration; never disturbs data already in the output slot.
- No in_valid asserted: grant=0, in_ready=0, slot drains normally.
- Protocol (bench assertion): in_valid[i] and in_data[i] stay stable from assertion until accepted.
- Fairness: in RR mode with all N valid continuously and out_ready=1, each channel is granted exactly once in every N consecutive transfers.

Decomposition:
- Shared package mux_pkg:
  - typedef enum logic {FIXED=1'b0, RR=1'b1} arb_mode_e.
  - Helper function for clog2-safe width (CW >= 1 when N=2).
- One sub-module, rr_pick (purely combinational):
  - Inputs: req[N], start[CW].
  - Outputs: gnt[N] one-hot, gnt_idx[CW], any.
  - Top drives start=0 in FIXED mode, start=ptr in RR mode.
  - Top holds all registers: output slot and ptr.

Test Plan:
- Reset mid-stream: out_valid=1 with out_data=8'hA5, assert reset asynchronously between edges -> out_valid, out_data, out_chan drop to 0 immediately; ptr=0 after release.
- FIXED mode, in_valid=4'b1010, out_ready=1, data ch1=8'h11 and ch3=8'h33 -> ch1 accepted first; next cycle out_data=8'h11, out_chan=1; ch3 accepted only after ch1 deasserts.
- RR mode, in_valid=4'b1111 held, out_ready=1, ch i data=8'h10+i -> out_chan sequence 0,1,2,3,0 on consecutive cycles, no bubbles, ptr wraps 3->0.
- Backpressure: out_valid=1 with out_data=8'h22, out_ready=0 for 3 cycles -> in_ready=4'b0000 and out_data stable at 8'h22; on out_ready=1 the pending ch accepts in the same cycle and out_valid stays 1.
- Sparse RR: ptr=2, in_valid=4'b0001 -> ch0 granted via wrap, next ptr=1; then in_valid=0 -> out_valid falls to 0 one cycle after drain, ptr stays 1.
- Mode switch: RR with ptr=3, in_valid=4'b1001, set mode=FIXED -> ch0 granted (not ch3); ptr unchanged at 3.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 stream selector.
//   arb_mode_e : arbitration policy (FIXED priority or round robin)
//   idx_width  : channel-index width, never below 1 bit
package mux_pkg;

    typedef enum logic {
        FIXED = 1'b0,
        RR    = 1'b1
    } arb_mode_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational first-set picker searching upward from a start index,
// wrapping N-1 -> 0. With start=0 this degenerates to fixed priority.
// Ports:
//   req     : request vector
//   start   : index searched first
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted request
//   any     : at least one request present
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-1:0] w_rot;
    int             w_sum;

    // Rotating a doubled copy puts the start channel at bit 0, so the
    // search becomes a plain lowest-set-bit scan.
    assign w_rot = {req, req} >> start;

    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        w_sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!any && w_rot[k]) begin
                any   = 1'b1;
                w_sum = int'(start) + k;
            end
        end
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        gnt_idx = CW'(w_sum);
        gnt     = any ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input valid/ready stream selector with fixed-priority or round-robin
// arbitration feeding a single registered output slot.
// Ports:
//   clk, reset          : clock, async active-high reset
//   mode                : FIXED (ch0 highest) or RR
//   in_valid/in_ready   : per-channel handshake, in_ready one-hot or zero
//   in_data             : packed per-channel data
//   out_valid/out_ready : output slot handshake
//   out_data/out_chan   : registered data and its source channel
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int CW    = idx_width(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  arb_mode_e                 mode,
    input  logic [N-1:0]              in_valid,
    output logic [N-1:0]              in_ready,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_out_chan;
    logic [CW-1:0]    r_ptr;

    logic             w_load_ok;
    logic             w_any;
    logic             w_xfer;
    logic [N-1:0]     w_gnt;
    logic [CW-1:0]    w_gnt_idx;
    logic [CW-1:0]    w_start;

    assign w_load_ok = !r_out_valid || out_ready;
    assign w_start   = (mode == RR) ? r_ptr : '0;

    rr_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .start   (w_start),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // The slot reads empty during reset, so reset must gate in_ready
    // explicitly or producers would see an accept that never lands.
    assign w_xfer   = w_any && w_load_ok && !reset;
    assign in_ready = (w_load_ok && !reset) ? w_gnt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_gnt_idx];
                r_out_chan  <= w_gnt_idx;
                if (mode == RR) begin
                    r_ptr <= (w_gnt_idx == CW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_arb_reg.sv
module tb_mux_arb_reg;
    import mux_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    logic                    clk;
    logic                    reset;
    arb_mode_e               mode;
    logic [N-1:0]            in_valid;
    logic [N-1:0]            in_ready;
    logic [N-1:0][WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [1:0]              out_chan;

    int total = 0;
    int bad   = 0;

    // reference model state
    int           m_ptr;
    logic         m_valid;
    logic [7:0]   m_data;
    int           m_chan;
    logic [N-1:0] last_acc;

    mux_arb_reg #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winning channel under the current policy, or -1 when nobody requests.
    function automatic int model_grant();
        int base;
        base = (mode == RR) ? m_ptr : 0;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        g = model_grant();
        if (g >= 0 && (!m_valid || out_ready)) return N'(1) << g;
        return '0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_chan = 0; last_acc = '0;
    endtask

    // Advance model and DUT by one clock; returns at posedge+1.
    task automatic tick();
        int g;
        g = model_grant();
        last_acc = '0;
        if (g >= 0 && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m_data  = in_data[g];
            m_chan  = g;
            last_acc[g] = 1'b1;
            if (mode == RR) m_ptr = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        model_reset();
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid, out_data, out_chan, in_ready} !== 15'd0) begin
            bad++;
            $display("FAIL reset_init: got v=%b d=%h c=%0d rdy=%b, want all zero",
                     out_valid, out_data, out_chan, in_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        mode = RR; out_ready = 1'b0;
        in_valid = 4'b0010; in_data[1] = 8'hA5;
        #2;
        total++;
        if (in_ready !== 4'b0010) begin
            bad++; $display("FAIL reset_pre_ready: got %b want 0010", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'hA5, 2'd1}) begin
            bad++;
            $display("FAIL reset_pre_load: got v=%b d=%h c=%0d want v=1 d=a5 c=1",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({out_valid, out_data, out_chan, in_ready} !== 15'd0) begin
            bad++;
            $display("FAIL reset_async: got v=%b d=%h c=%0d rdy=%b, want all zero",
                     out_valid, out_data, out_chan, in_ready);
        end
        #2 reset = 1'b0;
        in_valid = 4'b0001;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL reset_ptr_zero: got rdy=%b want 0001", in_ready);
        end
        @(posedge clk); #1;
        m_valid = 1'b1; m_data = 8'h10; m_chan = 0; m_ptr = 1;
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'h10, 2'd0}) begin
            bad++;
            $display("FAIL reset_post_load: got v=%b d=%h c=%0d want v=1 d=10 c=0",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        mode = FIXED; out_ready = 1'b1;
        in_valid = 4'b1010; in_data[1] = 8'h11; in_data[3] = 8'h33;
        #2;
        total++;
        if (in_ready !== 4'b0010) begin
            bad++; $display("FAIL fixed_ready1: got %b want 0010", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'h11, 2'd1}) begin
            bad++;
            $display("FAIL fixed_out1: got v=%b d=%h c=%0d want v=1 d=11 c=1",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b1000;
        #2;
        total++;
        if (in_ready !== 4'b1000) begin
            bad++; $display("FAIL fixed_ready3: got %b want 1000", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'h33, 2'd3}) begin
            bad++;
            $display("FAIL fixed_out3: got v=%b d=%h c=%0d want v=1 d=33 c=3",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL fixed_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_rr();
        apply_reset();
        mode = RR; out_ready = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            #2;
            total++;
            if (in_ready !== 4'(1 << (k % 4))) begin
                bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % 4)));
            end
            tick();
            total++;
            if ({out_valid, out_data, out_chan} !== {1'b1, 8'h10 + 8'(k % 4), 2'(k % 4)}) begin
                bad++;
                $display("FAIL rr_out[%0d]: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                         k, out_valid, out_data, out_chan, 8'h10 + 8'(k % 4), k % 4);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        mode = FIXED; out_ready = 1'b1;
        in_valid = 4'b0100; in_data[2] = 8'h22;
        tick();
        out_ready = 1'b0;
        in_valid = 4'b0001; in_data[0] = 8'h55;
        for (int k = 0; k < 3; k++) begin
            #2;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready);
            end
            tick();
            total++;
            if ({out_valid, out_data, out_chan} !== {1'b1, 8'h22, 2'd2}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d want v=1 d=22 c=2",
                         k, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1'b1;
        #2;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_release_ready: got %b want 0001", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'h55, 2'd0}) begin
            bad++;
            $display("FAIL bp_reload: got v=%b d=%h c=%0d want v=1 d=55 c=0",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_sparse_rr();
        apply_reset();
        mode = RR; out_ready = 1'b1;
        in_valid = 4'b0010; in_data[1] = 8'h01;
        tick();
        in_valid = 4'b0001; in_data[0] = 8'h77;
        #2;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL sparse_wrap_ready: got %b want 0001", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'h77, 2'd0}) begin
            bad++;
            $display("FAIL sparse_wrap_out: got v=%b d=%h c=%0d want v=1 d=77 c=0",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL sparse_drain: got v=%b want 0", out_valid);
        end
        tick();
        in_valid = 4'b0011; in_data[0] = 8'h70; in_data[1] = 8'h71;
        #2;
        total++;
        if (in_ready !== 4'b0010) begin
            bad++; $display("FAIL sparse_ptr_held: got %b want 0010", in_ready);
        end
        tick();
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_mode_switch();
        mode = RR; out_ready = 1'b1;
        in_valid = 4'b0100; in_data[2] = 8'h02;
        tick();
        in_valid = 4'b1001; in_data[0] = 8'hC0; in_data[3] = 8'hC3;
        mode = FIXED;
        #2;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++; $display("FAIL mode_fixed_ready: got %b want 0001", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'hC0, 2'd0}) begin
            bad++;
            $display("FAIL mode_fixed_out: got v=%b d=%h c=%0d want v=1 d=c0 c=0",
                     out_valid, out_data, out_chan);
        end
        mode = RR; in_data[0] = 8'hD0;
        #2;
        total++;
        if (in_ready !== 4'b1000) begin
            bad++; $display("FAIL mode_ptr_kept: got %b want 1000", in_ready);
        end
        tick();
        total++;
        if ({out_valid, out_data, out_chan} !== {1'b1, 8'hC3, 2'd3}) begin
            bad++;
            $display("FAIL mode_rr_out: got v=%b d=%h c=%0d want v=1 d=c3 c=3",
                     out_valid, out_data, out_chan);
        end
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        last_acc = '0;
        for (int it = 0; it < 300; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || last_acc[i]) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_data[i]  = 8'($urandom);
                end
            end
            mode      = arb_mode_e'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            exp_rdy = model_ready();
            total++;
            if (in_ready !== exp_rdy) begin
                bad++; $display("FAIL rand_ready[%0d]: got %b want %b", it, in_ready, exp_rdy);
            end
            tick();
            total++;
            if (out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || out_chan !== 2'(m_chan)))) begin
                bad++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         it, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        mode      = FIXED;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_fixed();
        test_rr();
        test_backpressure();
        test_sparse_rr();
        test_mode_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
